mostrador_scan_ctrl: RTL and testbench

Sequencing controller for the irrigation-system 7-segment display. It replaces the static view-select and digit-enable ties with registered control:
- generates the view-select `Sd` for the level/irrigation-type segment decoder;
- scans the active-low digit enables with dead time;
- auto-alternates between the level and irrigation views;
- forces and blinks the level view on `ERRO`.

It sits between the system flags and the segment decoder; the decoder output is gated by `Blank`.

---
 rtl/mostrador_scan_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mostrador_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mostrador_scan_ctrl.sv
// Display sequencing for the irrigation 7-segment: view select, digit scan, error blink.
// Optional decimal-point heartbeat output when MOSTRADOR_DP_HEARTBEAT_EN is defined.
module mostrador_scan_ctrl #(
    parameter int          PRESC_DIV   = 50000,
    parameter int          VIEW_TICKS  = 1000,
    parameter int          BLINK_TICKS = 250,
    parameter int          DEAD_CYC    = 2,
    parameter logic [3:0]  DIG_MASK    = 4'b0001
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Auto_En,
    input  logic       Sd_Man,
    input  logic       ERRO,
    input  logic       Bs,
    input  logic       Vs,
    output logic       Sd,
    output logic [3:0] Dig_Sel,
    output logic       Blank,
    output logic       Scan_Tick
`ifdef MOSTRADOR_DP_HEARTBEAT_EN
    ,
    output logic       Dp_Out
`endif
);

    localparam int PW = $clog2(PRESC_DIV);
    localparam int VW = $clog2(VIEW_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam int DW = $clog2(DEAD_CYC + 1);

    localparam logic [PW-1:0] P_LAST = PW'(PRESC_DIV - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VIEW_TICKS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [DW-1:0] D_LOAD = DW'(DEAD_CYC);

    localparam logic [1:0] S_LEVEL = 2'd0;
    localparam logic [1:0] S_IRRIG = 2'd1;
    localparam logic [1:0] S_ERR   = 2'd2;

    function automatic logic [1:0] top_digit(input logic [3:0] m);
        logic [1:0] t;
        t = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) t = 2'(i);
        end
        return t;
    endfunction

    // Parking on the highest digit makes the first scan land on the lowest one.
    localparam logic [1:0] PTR_INIT = top_digit(DIG_MASK);

    logic [PW-1:0] presc;
    logic          tick;
    logic [1:0]    ptr;
    logic [1:0]    ptr_nxt;
    logic [1:0]    idx;
    logic [DW-1:0] dead;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [VW-1:0] vcnt;
    logic [VW-1:0] vcnt_nxt;
    logic [BW-1:0] bcnt;
    logic          blink;
    logic [DW-1:0] vdead;
    logic          busy;
    logic          sd_nxt;

    assign tick      = (presc == P_LAST);
    assign Scan_Tick = tick;
    assign busy      = Bs | Vs;
    assign sd_nxt    = (state_nxt == S_IRRIG);
    assign Blank     = blink | (vdead != '0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        idx     = ptr;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (DIG_MASK[idx]) ptr_nxt = idx;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr     <= PTR_INIT;
            dead    <= '0;
            Dig_Sel <= 4'b1111;
        end else if (tick) begin
            ptr     <= ptr_nxt;
            dead    <= D_LOAD;
            Dig_Sel <= 4'b1111;
        end else if (dead != '0) begin
            dead <= dead - 1'b1;
            if (dead == DW'(1)) Dig_Sel <= ~(4'b0001 << ptr);
        end
    end

    always_comb begin
        state_nxt = state;
        vcnt_nxt  = vcnt;
        if (ERRO) begin
            state_nxt = S_ERR;
            vcnt_nxt  = '0;
        end else if (state != S_LEVEL && state != S_IRRIG) begin
            state_nxt = S_LEVEL;
            vcnt_nxt  = '0;
        end else if (!Auto_En) begin
            state_nxt = Sd_Man ? S_IRRIG : S_LEVEL;
            vcnt_nxt  = '0;
        end else if (state == S_IRRIG && !busy) begin
            state_nxt = S_LEVEL;
            vcnt_nxt  = '0;
        end else if (tick) begin
            if (vcnt == V_LAST) begin
                vcnt_nxt  = '0;
                state_nxt = (state == S_LEVEL && busy) ? S_IRRIG : S_LEVEL;
            end else begin
                vcnt_nxt = vcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_LEVEL;
            vcnt  <= '0;
            Sd    <= 1'b0;
            vdead <= '0;
        end else begin
            state <= state_nxt;
            vcnt  <= vcnt_nxt;
            Sd    <= sd_nxt;
            if (sd_nxt != Sd) begin
                vdead <= D_LOAD;
            end else if (vdead != '0) begin
                vdead <= vdead - 1'b1;
            end
        end
    end

    // Blink phase restarts on every entry into the error view.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bcnt  <= '0;
            blink <= 1'b0;
        end else if (state != S_ERR || state_nxt != S_ERR) begin
            bcnt  <= '0;
            blink <= 1'b0;
        end else if (tick) begin
            if (bcnt == B_LAST) begin
                bcnt  <= '0;
                blink <= ~blink;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

`ifdef MOSTRADOR_DP_HEARTBEAT_EN
    logic [BW-1:0] hcnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hcnt   <= '0;
            Dp_Out <= 1'b0;
        end else if (!Auto_En || state == S_ERR) begin
            hcnt   <= '0;
            Dp_Out <= 1'b0;
        end else if (tick) begin
            if (hcnt == B_LAST) begin
                hcnt   <= '0;
                Dp_Out <= ~Dp_Out;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mostrador_scan_ctrl.sv
// Bench for mostrador_scan_ctrl: hand vectors, table rows and random inputs
// checked against a tick-counting reference model.
module tb_mostrador_scan_ctrl;

    localparam int         P = 4;
    localparam int         V = 3;
    localparam int         B = 2;
    localparam int         D = 1;
    localparam logic [3:0] M = 4'b0101;

    logic       Clk;
    logic       Rst_n;
    logic       Auto_En;
    logic       Sd_Man;
    logic       ERRO;
    logic       Bs;
    logic       Vs;
    logic       Sd;
    logic [3:0] Dig_Sel;
    logic       Blank;
    logic       Scan_Tick;
`ifdef MOSTRADOR_DP_HEARTBEAT_EN
    logic       Dp_Out;
`endif

    mostrador_scan_ctrl #(
        .PRESC_DIV  (P),
        .VIEW_TICKS (V),
        .BLINK_TICKS(B),
        .DEAD_CYC   (D),
        .DIG_MASK   (M)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Auto_En  (Auto_En),
        .Sd_Man   (Sd_Man),
        .ERRO     (ERRO),
        .Bs       (Bs),
        .Vs       (Vs),
        .Sd       (Sd),
        .Dig_Sel  (Dig_Sel),
        .Blank    (Blank),
        .Scan_Tick(Scan_Tick)
`ifdef MOSTRADOR_DP_HEARTBEAT_EN
        ,
        .Dp_Out   (Dp_Out)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: counts edges and scan ticks since reset.
    int m_n, m_ticks, m_last, m_view, m_vt, m_et, m_chg;
    bit m_sd;
    int en_list[$];

    task automatic model_reset();
        m_n = 0; m_ticks = 0; m_last = 0;
        m_view = 0; m_vt = 0; m_et = 0;
        m_chg = -1; m_sd = 0;
    endtask

    task automatic model_edge();
        bit tk;
        bit nsd;
        tk = ((m_n % P) == P - 1);
        m_n++;
        if (tk) begin
            m_ticks++;
            m_last = m_n;
        end
        if (ERRO) begin
            if (m_view != 2) m_et = 0;
            else if (tk) m_et++;
            m_view = 2; m_vt = 0;
        end else if (m_view == 2) begin
            m_view = 0; m_vt = 0;
        end else if (!Auto_En) begin
            m_view = Sd_Man ? 1 : 0; m_vt = 0;
        end else if (m_view == 1 && !(Bs || Vs)) begin
            m_view = 0; m_vt = 0;
        end else if (tk) begin
            m_vt++;
            if (m_vt == V) begin
                m_vt = 0;
                m_view = (m_view == 0 && (Bs || Vs)) ? 1 : 0;
            end
        end
        nsd = (m_view == 1);
        if (nsd != m_sd) m_chg = m_n;
        m_sd = nsd;
    endtask

    task automatic model_check();
        int ed;
        int eb;
        if (m_ticks == 0 || (m_n - m_last) < D) ed = 15;
        else ed = 15 ^ (1 << en_list[(m_ticks - 1) % en_list.size()]);
        eb = ((m_view == 2) && ((m_et / B) % 2 == 1)) ||
             (m_chg >= 0 && (m_n - m_chg) < D);
        check("model_tick", Scan_Tick, ((m_n % P) == P - 1));
        check("model_dig", Dig_Sel, ed);
        check("model_sd", Sd, m_sd);
        check("model_blank", Blank, eb);
    endtask

    task automatic clk_step();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        model_check();
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        model_reset();
        Rst_n = 1'b1;
    endtask

    typedef struct {
        int cyc;
        bit ae, sm, er, bs, vs;
        bit sd, bl;
    } vec_t;

    vec_t tab[17];

    initial begin
        logic [3:0] mask_v;
        int st_exp[6];
        int dg_exp[6];

        tab[0]  = '{12, 1, 0, 0, 1, 0, 1, 1};
        tab[1]  = '{1,  1, 0, 0, 1, 0, 1, 0};
        tab[2]  = '{11, 1, 0, 0, 1, 0, 0, 1};
        tab[3]  = '{12, 1, 0, 0, 1, 0, 1, 1};
        tab[4]  = '{1,  1, 0, 0, 0, 0, 0, 1};
        tab[5]  = '{11, 1, 0, 0, 1, 0, 1, 1};
        tab[6]  = '{1,  1, 0, 1, 1, 0, 0, 1};
        tab[7]  = '{7,  1, 0, 1, 1, 0, 0, 1};
        tab[8]  = '{1,  1, 0, 1, 1, 0, 0, 1};
        tab[9]  = '{7,  1, 0, 1, 1, 0, 0, 0};
        tab[10] = '{8,  1, 0, 1, 1, 0, 0, 1};
        tab[11] = '{1,  1, 0, 0, 1, 0, 0, 0};
        tab[12] = '{1,  0, 1, 0, 1, 0, 1, 1};
        tab[13] = '{80, 0, 1, 0, 1, 0, 1, 0};
        tab[14] = '{1,  0, 1, 1, 1, 0, 0, 1};
        tab[15] = '{1,  0, 1, 0, 1, 0, 0, 0};
        tab[16] = '{1,  0, 1, 0, 1, 0, 1, 1};

        st_exp = '{0, 0, 1, 0, 0, 0};
        dg_exp = '{15, 15, 15, 15, 14, 14};

        mask_v = M;
        for (int i = 0; i < 4; i++) begin
            if (mask_v[i]) en_list.push_back(i);
        end

        Rst_n = 1'b0; Auto_En = 1'b0; Sd_Man = 1'b0;
        ERRO = 1'b0; Bs = 1'b0; Vs = 1'b0;
        model_reset();

        do_reset();
        check("reset_dig", Dig_Sel, 15);
        check("reset_sd", Sd, 0);
        check("reset_blank", Blank, 0);
        check("reset_tick", Scan_Tick, 0);
        for (int e = 0; e < 6; e++) begin
            clk_step();
            check("first_tick", Scan_Tick, st_exp[e]);
            check("first_dig", Dig_Sel, dg_exp[e]);
        end

        do_reset();
        for (int r = 0; r < 17; r++) begin
            Auto_En = tab[r].ae; Sd_Man = tab[r].sm; ERRO = tab[r].er;
            Bs = tab[r].bs; Vs = tab[r].vs;
            repeat (tab[r].cyc) clk_step();
            check($sformatf("tab%0d_sd", r), Sd, tab[r].sd);
            check($sformatf("tab%0d_blank", r), Blank, tab[r].bl);
        end

        // Asynchronous reset while a digit is lit and the irrigation view is shown.
        #2 Rst_n = 1'b0;
        #1;
        check("async_dig", Dig_Sel, 15);
        check("async_sd", Sd, 0);
        check("async_blank", Blank, 0);
        check("async_tick", Scan_Tick, 0);
        @(negedge Clk);
        model_reset();
        Auto_En = 1'b1; Sd_Man = 1'b0; ERRO = 1'b0; Bs = 1'b1; Vs = 1'b0;
        Rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 1) Auto_En = ~Auto_En;
            if ($urandom_range(0, 99) < 2) Sd_Man = ~Sd_Man;
            if ($urandom_range(0, 99) < 3) Bs = ~Bs;
            if ($urandom_range(0, 99) < 3) Vs = ~Vs;
            if (ERRO) begin
                if ($urandom_range(0, 99) < 4) ERRO = 1'b0;
            end else begin
                if ($urandom_range(0, 99) < 1) ERRO = 1'b1;
            end
            clk_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
